// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared core types: CDB entry layout and machine-size constants
//   N_ALU, N_MUL   : functional-unit counts feeding the CDB
//   ROB_DEPTH      : reorder-buffer entries, sets the rob_id width
//   cdb_entry_t    : one result as broadcast on a CDB lane
//   cdb_entry_w()  : packed width of a CDB entry for a given ROB depth
//   ptr_w()        : width of an index into n slots (at least 1 bit)
package rv32i_types;

  localparam int N_ALU     = 2;
  localparam int N_MUL     = 2;
  localparam int ROB_DEPTH = 8;
  localparam int PD_W      = 6;
  localparam int RD_W      = 5;

  typedef struct packed {
    logic [$clog2(ROB_DEPTH)-1:0] rob_id;
    logic [PD_W-1:0]              pd;
    logic [RD_W-1:0]              rd;
    logic [31:0]                  value;
    logic                         is_branch;
    logic                         branch_taken;
    logic                         predict_branch;
  } cdb_entry_t;

  // Same field order as cdb_entry_t, but with rob_id sized by an arbitrary
  // ROB depth so arbiters built for other depths keep the full rob_id.
  function automatic int cdb_entry_w(input int rob_depth);
    return $clog2(rob_depth) + PD_W + RD_W + 32 + 3;
  endfunction

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// rtl/cdb_rr_picker.sv - combinational multi-grant round-robin picker
//   req        : per-slot request vector
//   ptr        : slot where the circular scan starts
//   sel        : per-lane one-hot slot select (k-th grant in scan order -> lane k)
//   lane_valid : lane k received a grant
//   next_ptr   : one past the last granted slot, or ptr when nothing granted
module cdb_rr_picker
  import rv32i_types::*;
#(
  parameter int N_SRC  = 4,
  parameter int N_PORT = 2
) (
  input  logic [N_SRC-1:0]                    req,
  input  logic [ptr_w(N_SRC)-1:0]             ptr,
  output logic [N_PORT-1:0][N_SRC-1:0]        sel,
  output logic [N_PORT-1:0]                   lane_valid,
  output logic [ptr_w(N_SRC)-1:0]             next_ptr
);

  localparam int PW = ptr_w(N_SRC);

  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int off);
    int s;
    s = (int'(p) + off) % N_SRC;
    return PW'(s);
  endfunction

  logic [PW-1:0] idx;

  // rank counts requesters already seen in scan order; the requester whose
  // rank equals k owns lane k. Ranks beyond N_PORT-1 simply get no lane.
  always_comb begin
    int rank;
    rank       = 0;
    idx        = '0;
    sel        = '0;
    lane_valid = '0;
    next_ptr   = ptr;
    for (int j = 0; j < N_SRC; j++) begin
      idx = wrap(ptr, j);
      if (req[idx]) begin
        for (int k = 0; k < N_PORT; k++) begin
          if (rank == k) begin
            sel[k][idx]   = 1'b1;
            lane_valid[k] = 1'b1;
            next_ptr      = wrap(idx, 1);
          end
        end
        rank = rank + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-unit result holding slots driven round-robin onto the CDB lanes
//   clk, rst   : clock, asynchronous active-low reset
//   flush      : mispredict flush, drops every buffered and pending result
//   fu_valid   : unit i presents a result on fu_result[i]
//   fu_result  : per-unit result payload (cdb_entry_t layout)
//   fu_ready   : slot i takes the presented result on this edge
//   cdb_valid  : lane k carries a result (no back-pressure on the bus)
//   cdb_out    : lane payload, holds its last value while the lane is idle
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int N_SRC     = N_ALU + N_MUL,
  parameter int N_PORT    = 2,
  parameter int ROB_DEPTH = rv32i_types::ROB_DEPTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush,
  input  logic [N_SRC-1:0]                              fu_valid,
  input  logic [N_SRC-1:0][cdb_entry_w(ROB_DEPTH)-1:0]  fu_result,
  output logic [N_SRC-1:0]                              fu_ready,
  output logic [N_PORT-1:0]                             cdb_valid,
  output logic [N_PORT-1:0][cdb_entry_w(ROB_DEPTH)-1:0] cdb_out
);

  localparam int EW = cdb_entry_w(ROB_DEPTH);
  localparam int PW = ptr_w(N_SRC);

  logic [N_SRC-1:0]             hold_valid;
  logic [N_SRC-1:0][EW-1:0]     hold;
  logic [PW-1:0]                rr_ptr;
  logic [PW-1:0]                next_ptr;
  logic [N_PORT-1:0][N_SRC-1:0] sel;
  logic [N_PORT-1:0]            lane_valid;
  logic [N_SRC-1:0]             grant;
  logic [N_PORT-1:0][EW-1:0]    lane_data;

  cdb_rr_picker #(
    .N_SRC  (N_SRC),
    .N_PORT (N_PORT)
  ) u_picker (
    .req        (hold_valid),
    .ptr        (rr_ptr),
    .sel        (sel),
    .lane_valid (lane_valid),
    .next_ptr   (next_ptr)
  );

  always_comb begin
    grant     = '0;
    lane_data = '0;
    for (int k = 0; k < N_PORT; k++) begin
      grant = grant | sel[k];
      for (int i = 0; i < N_SRC; i++) begin
        if (sel[k][i]) lane_data[k] = lane_data[k] | hold[i];
      end
    end
  end

  // A slot being granted this cycle is free again at the edge, so the unit
  // may refill it in the same cycle; rst is folded in so nothing looks
  // accepted while the arbiter is held in reset.
  assign fu_ready = {N_SRC{rst & ~flush}} & (~hold_valid | grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= '0;
      hold       <= '0;
      rr_ptr     <= '0;
      cdb_valid  <= '0;
      cdb_out    <= '0;
    end else if (flush) begin
      hold_valid <= '0;
      cdb_valid  <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          hold[i]       <= fu_result[i];
          hold_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      cdb_valid <= lane_valid;
      for (int k = 0; k < N_PORT; k++) begin
        if (lane_valid[k]) cdb_out[k] <= lane_data[k];
      end
      rr_ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int NS   = 4;
  localparam int NP   = 2;
  localparam int EW16 = cdb_entry_w(16);

  logic                        clk;
  logic                        rst;
  logic                        flush;
  logic [NS-1:0]               fu_valid;
  cdb_entry_t [NS-1:0]         fu_result;
  logic [NS-1:0]               fu_ready;
  logic [NP-1:0]               cdb_valid;
  cdb_entry_t [NP-1:0]         cdb_out;

  logic                        flush16;
  logic [NS-1:0]               fu_valid16;
  logic [NS-1:0][EW16-1:0]     fu_result16;
  logic [NS-1:0]               fu_ready16;
  logic [NP-1:0]               cdb_valid16;
  logic [NP-1:0][EW16-1:0]     cdb_out16;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.N_SRC(NS), .N_PORT(NP)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_result (fu_result),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_out   (cdb_out)
  );

  cdb_arbiter #(.N_SRC(NS), .N_PORT(NP), .ROB_DEPTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush16),
    .fu_valid  (fu_valid16),
    .fu_result (fu_result16),
    .fu_ready  (fu_ready16),
    .cdb_valid (cdb_valid16),
    .cdb_out   (cdb_out16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cdb_entry_t mk(input int id, input logic [31:0] v);
    cdb_entry_t e;
    e                = '0;
    e.rob_id         = 3'(id);
    e.pd             = 6'(id + 10);
    e.rd             = 5'(id + 1);
    e.value          = v;
    e.is_branch      = id[0];
    e.branch_taken   = id[1];
    e.predict_branch = id[0];
    return e;
  endfunction

  // Model: per-slot pending results, a scan pointer, and the registered lanes.
  cdb_entry_t m_hold [NS];
  bit         m_hv   [NS];
  int         m_ptr;
  logic [NP-1:0] m_cv;
  cdb_entry_t m_out  [NP];
  int         m_q[$];

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_hv[i]   = 1'b0;
      m_hold[i] = '0;
    end
    for (int k = 0; k < NP; k++) m_out[k] = '0;
    m_ptr = 0;
    m_cv  = '0;
  endfunction

  // Slots that win a lane this cycle, in lane order.
  function automatic void model_pick();
    m_q.delete();
    for (int j = 0; j < NS; j++) begin
      int s;
      s = (m_ptr + j) % NS;
      if (m_hv[s] && m_q.size() < NP) m_q.push_back(s);
    end
  endfunction

  function automatic bit picked(input int s);
    foreach (m_q[n]) if (m_q[n] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NS-1:0] model_ready();
    logic [NS-1:0] r;
    model_pick();
    for (int i = 0; i < NS; i++) r[i] = rst && !flush && (!m_hv[i] || picked(i));
    return r;
  endfunction

  function automatic void model_step();
    logic [NS-1:0] r;
    r = model_ready();
    if (flush) begin
      for (int i = 0; i < NS; i++) m_hv[i] = 1'b0;
      m_cv  = '0;
      m_ptr = 0;
    end else begin
      m_cv = '0;
      foreach (m_q[k]) begin
        m_cv[k]  = 1'b1;
        m_out[k] = m_hold[m_q[k]];
      end
      if (m_q.size() > 0) m_ptr = (m_q[m_q.size()-1] + 1) % NS;
      for (int i = 0; i < NS; i++) begin
        if (fu_valid[i] && r[i]) begin
          m_hold[i] = fu_result[i];
          m_hv[i]   = 1'b1;
        end else if (picked(i)) begin
          m_hv[i] = 1'b0;
        end
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      check("model cdb_valid", 64'(cdb_valid), 64'(m_cv));
      check("model cdb_out0", 64'(cdb_out[0]), 64'(m_out[0]));
      check("model cdb_out1", 64'(cdb_out[1]), 64'(m_out[1]));
      check("model fu_ready", 64'(fu_ready), 64'(model_ready()));
      if (rst) model_step();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #60000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    rst         = 1'b0;
    flush       = 1'b0;
    fu_valid    = '0;
    fu_result   = '0;
    flush16     = 1'b0;
    fu_valid16  = '0;
    fu_result16 = '0;

    // reset
    @(negedge clk);
    check("reset cdb_valid", 64'(cdb_valid), 64'h0);
    check("reset fu_ready", 64'(fu_ready), 64'h0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("post-reset fu_ready", 64'(fu_ready), 64'hF);

    // single result from unit 2
    cyc();
    fu_valid     = 4'b0100;
    fu_result[2] = mk(5, 32'hDEADBEEF);
    cyc();
    fu_valid = '0;
    cyc();
    @(negedge clk);
    check("single cdb_valid", 64'(cdb_valid), 64'h1);
    check("single rob_id", 64'(cdb_out[0].rob_id), 64'd5);
    check("single value", 64'(cdb_out[0].value), 64'hDEADBEEF);
    check("single rr_ptr", 64'(dut.rr_ptr), 64'd3);

    // contention: all four slots full with rr_ptr = 3
    cyc();
    fu_valid = 4'b1111;
    for (int i = 0; i < NS; i++) fu_result[i] = mk(i + 4, 32'h100 + i);
    cyc();
    fu_valid = '0;
    @(negedge clk);
    check("cont fu_ready", 64'(fu_ready), 64'b1001);
    cyc();
    @(negedge clk);
    check("cont c1 valid", 64'(cdb_valid), 64'b11);
    check("cont c1 lane0", 64'(cdb_out[0].value), 64'h103);
    check("cont c1 lane1", 64'(cdb_out[1].value), 64'h100);
    cyc();
    @(negedge clk);
    check("cont c2 valid", 64'(cdb_valid), 64'b11);
    check("cont c2 lane0", 64'(cdb_out[0].value), 64'h101);
    check("cont c2 lane1", 64'(cdb_out[1].value), 64'h102);
    check("cont drained", 64'(dut.hold_valid), 64'h0);

    // back-to-back stream from unit 0
    for (int n = 0; n < 8; n++) begin
      cyc();
      fu_valid     = (n < 6) ? 4'b0001 : 4'b0000;
      fu_result[0] = mk(n, 32'h2000 + n);
      @(negedge clk);
      check("b2b fu_ready0", 64'(fu_ready[0]), 64'h1);
      if (n >= 2) begin
        check("b2b cdb_valid", 64'(cdb_valid), 64'h1);
        check("b2b rob_id", 64'(cdb_out[0].rob_id), 64'(n - 2));
      end
    end

    // flush with three slots and two lanes valid
    cyc();
    fu_valid = 4'b0111;
    for (int i = 0; i < 3; i++) fu_result[i] = mk(i, 32'h300 + i);
    cyc();
    fu_valid = 4'b0110;
    fu_result[1] = mk(6, 32'h311);
    fu_result[2] = mk(7, 32'h312);
    cyc();
    flush        = 1'b1;
    fu_valid     = 4'b1000;
    fu_result[3] = mk(3, 32'h333);
    @(negedge clk);
    check("pre-flush cdb_valid", 64'(cdb_valid), 64'b11);
    check("pre-flush slots", 64'(dut.hold_valid), 64'b0111);
    check("flush fu_ready", 64'(fu_ready), 64'h0);
    cyc();
    flush    = 1'b0;
    fu_valid = '0;
    @(negedge clk);
    check("flush cdb_valid", 64'(cdb_valid), 64'h0);
    check("flush slots", 64'(dut.hold_valid), 64'h0);
    check("flush rr_ptr", 64'(dut.rr_ptr), 64'h0);
    cyc();
    @(negedge clk);
    check("flush not captured", 64'(cdb_valid), 64'h0);

    // reset mid-traffic
    cyc();
    fu_valid = 4'b1111;
    for (int i = 0; i < NS; i++) fu_result[i] = mk(i + 1, 32'h400 + i);
    cyc();
    fu_valid = '0;
    cyc();
    @(negedge clk);
    check("pre-reset cdb_valid", 64'(cdb_valid), 64'b11);
    #2;
    rst = 1'b0;
    #1;
    check("midreset cdb_valid", 64'(cdb_valid), 64'h0);
    check("midreset fu_ready", 64'(fu_ready), 64'h0);
    @(negedge clk);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("release fu_ready", 64'(fu_ready), 64'hF);
    check("release cdb_valid", 64'(cdb_valid), 64'h0);

    // 16-entry ROB keeps the full rob_id
    cyc();
    fu_valid16     = 4'b0001;
    fu_result16[0] = {4'd13, 6'd7, 5'd3, 32'hCAFE0013, 3'b110};
    cyc();
    fu_valid16 = '0;
    cyc();
    @(negedge clk);
    check("rob16 valid", 64'(cdb_valid16), 64'h1);
    check("rob16 rob_id", 64'(cdb_out16[0][EW16-1 -: 4]), 64'd13);
    check("rob16 entry", 64'(cdb_out16[0]), {14'h0, 4'd13, 6'd7, 5'd3, 32'hCAFE0013, 3'b110});

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from the functional units and drives them onto the `N_PORT` lanes of the common data bus that the reorder buffer, reservation stations and register file snoop. Each unit owns one holding slot here, so a unit with a finished result is back-pressured only when its slot is occupied and not granted. Slots are granted round-robin with a registered bus output. Buffered results are discarded on a mispredict flush.

## Interface
- `N_SRC`, default 4: number of functional-unit sources (`N_ALU + N_MUL`).
- `N_PORT`, default 2: number of CDB lanes. Constraint: `1 <= N_PORT <= N_SRC`.
- `ROB_DEPTH`, default 8: sets the `rob_id` width to `$clog2(ROB_DEPTH)`.
- `clk` in, 1: the single clock.
- `rst` in, 1: asynchronous, active-low reset.
- `flush` in, 1: mispredict flush from the reorder buffer; sampled synchronously.
- `fu_valid` in, `N_SRC`: unit i presents a result.
- `fu_result` in, `cdb_entry_t [N_SRC]`: result payload.
- `fu_ready` out, `N_SRC`: slot i accepts on this edge.
- `cdb_valid` out, `N_PORT`: lane k carries a result.
- `cdb_out` out, `cdb_entry_t [N_PORT]`: lane payload.

## Operation
- **State.** Per source: `hold_valid[i]` and `hold[i]`. Globally: `rr_ptr`, `$clog2(N_SRC)` bits, plus the output registers.
- **Ready.** `fu_ready[i] = !flush && (!hold_valid[i] || grant[i])`.
  - This path is combinational from grant to ready, which allows one result per unit per cycle.
- **Accept.** `fu_valid[i] && fu_ready[i]` loads `hold[i]` and sets `hold_valid[i]`.
  - Otherwise a granted slot clears.
  - An ungranted slot holds.
- **Pick.**
  - Scan `hold_valid` circularly, starting at index `rr_ptr`.
  - Grant the first `min(N_PORT, count)` valid slots.
  - The k-th grant in scan order goes to lane k.
  - Unused lanes are invalid.
- **Pointer.** Next `rr_ptr` = (index of the last granted slot + 1) mod `N_SRC`. It is unchanged when nothing is granted.
- **Output.**
  - Each edge loads `cdb_valid[k]` and `cdb_out[k]` from the grants.
  - `cdb_out` of an invalid lane holds its previous value.
  - No handshake exists on the bus: consumers must take every valid lane.
- **Flush.** On the edge where `flush` is high:
  - all `hold_valid` are cleared;
  - all `cdb_valid` are cleared;
  - `rr_ptr` is set to 0;
  - no input is accepted.
- **Width rule.** `rob_id` is carried at the full `$clog2(ROB_DEPTH)` width, with no truncation. The value is 32 bits, passed unchanged.

## Timing
- **Reset value** (asynchronous, active low):
  - `hold_valid` = 0, `rr_ptr` = 0, `cdb_valid` = 0, `cdb_out` = 0.
  - `fu_ready` = all ones once `rst` is deasserted and `flush` is low.
- **Latency.**
  - A result accepted at edge E0 appears on `cdb_out` after edge E1 at the earliest, i.e. visible during cycle 2 after presentation.
  - Worst-case wait after acceptance is `ceil(N_SRC/N_PORT)` grant cycles.
- **Full.** All slots are valid and ungranted, so `fu_ready` = 0 for those units. This only happens when `N_SRC > N_PORT`.
- **Empty.** No grants; `cdb_valid` = 0 on the next edge; `rr_ptr` is unchanged.
- **Wrap-around.** The scan from `rr_ptr = N_SRC-1` continues at index 0. Lane order follows scan order, not index order.
- **Simultaneous grant + accept on one slot.** The slot reloads with the new result; the old result leaves on the lane.
- **Flush with a grant pending.** The grant is dropped; `flush` overrides the output load.
- **Reset mid-operation.** All buffered and in-flight results are lost immediately; no partial lane survives.

## Structure
- `cdb_entry_t` belongs in the shared `rv32i_types` package, containing:
  - `rob_id` `[$clog2(ROB_DEPTH)-1:0]`;
  - `pd`;
  - `rd`;
  - `value [31:0]`;
  - `is_branch`;
  - `branch_taken`;
  - `predict_branch`.
- `N_ALU`, `N_MUL` and `ROB_DEPTH` constants also belong in `rv32i_types`.
- One sub-module: `cdb_rr_picker`, a purely combinational multi-grant round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: per-lane one-hot select, lane-valid, and next pointer.
  - Holding registers and output registers stay in `cdb_arbiter`.

## Test plan
- **Reset.** Hold `rst` = 0 mid-traffic → `cdb_valid` = 00 and `fu_ready` = 0000 at once; after release, `fu_ready` = 1111.
- **Single result.** Unit 2 presents `rob_id` = 5, value = 0xDEADBEEF → lane 0 valid with exactly that payload 2 cycles later; lane 1 invalid; `rr_ptr` becomes 3.
- **Contention** (N_SRC=4, N_PORT=2, `rr_ptr` = 3, all four slots valid) →
  - cycle 1: lanes = {3, 0};
  - cycle 2: lanes = {1, 2};
  - all four drained in 2 cycles;
  - `fu_ready` for slots 1 and 2 is low during cycle 1.
- **Back-to-back.** Unit 0 streams one result per cycle with no other traffic → `fu_ready[0]` stays 1 and lane 0 carries a new `rob_id` every cycle, in order.
- **Flush.** Assert `flush` for one cycle with 3 slots valid and 2 lanes valid → next cycle `cdb_valid` = 00, all slots empty, `rr_ptr` = 0, and the input presented during the flush cycle is not captured.
- **ROB width.** With `ROB_DEPTH` = 16, `rob_id` = 13 → 13 appears on the lane unchanged.
